// File: rtl/vga_timing_pkg.sv
// Shared types and 640x480@60 default timing for the VGA raster generator.
package vga_timing_pkg;

  typedef enum logic [1:0] {
    ST_ACTIVE = 2'd0,
    ST_FRONT  = 2'd1,
    ST_SYNC   = 2'd2,
    ST_BACK   = 2'd3
  } axis_st_t;

  localparam int unsigned DEF_H_ACTIVE = 32'd640;
  localparam int unsigned DEF_H_FP     = 32'd16;
  localparam int unsigned DEF_H_SYNC   = 32'd96;
  localparam int unsigned DEF_H_BP     = 32'd48;
  localparam int unsigned DEF_V_ACTIVE = 32'd480;
  localparam int unsigned DEF_V_FP     = 32'd10;
  localparam int unsigned DEF_V_SYNC   = 32'd2;
  localparam int unsigned DEF_V_BP     = 32'd33;
  localparam int unsigned DEF_CH_W     = 32'd10;
  localparam int unsigned DEF_CV_W     = 32'd10;

  function automatic logic sync_level(input axis_st_t st, input logic pol);
    return (st == ST_SYNC) ? pol : ~pol;
  endfunction

endpackage

// File: rtl/vga_axis_fsm.sv
// One raster axis: counter plus ACTIVE/FRONT/SYNC/BACK region FSM.
// Exposes next-state so the top can register outputs aligned with the count.
module vga_axis_fsm
  import vga_timing_pkg::*;
#(
  parameter int unsigned ACTIVE = 32'd640,
  parameter int unsigned FP     = 32'd16,
  parameter int unsigned SYNC   = 32'd96,
  parameter int unsigned BP     = 32'd48,
  parameter int unsigned W      = 32'd10
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clear_i,
  input  logic         advance_i,
  output logic         wrap_o,
  output logic [W-1:0] count_o,
  output axis_st_t     state_d_o
);

  localparam int unsigned TOTAL   = ACTIVE + FP + SYNC + BP;
  localparam logic [W-1:0] LAST    = W'(TOTAL - 32'd1);
  localparam logic [W-1:0] B_FRONT = W'(ACTIVE);
  localparam logic [W-1:0] B_SYNC  = W'(ACTIVE + FP);
  localparam logic [W-1:0] B_BACK  = W'(ACTIVE + FP + SYNC);
  // Zero-width regions are skipped by choosing the successor at elaboration.
  localparam axis_st_t ST_AFTER_FRONT  = (SYNC != 32'd0) ? ST_SYNC : ST_BACK;
  localparam axis_st_t ST_AFTER_ACTIVE = (FP != 32'd0) ? ST_FRONT : ST_AFTER_FRONT;

  logic [W-1:0] count_q, count_d;
  axis_st_t     state_q, state_d;

  assign wrap_o = advance_i & (count_q == LAST);

  // Next count and region; clear wins over advance.
  always_comb begin
    count_d = count_q;
    state_d = state_q;
    if (clear_i) begin
      count_d = LAST;
      state_d = ST_BACK;
    end else if (advance_i) begin
      if (count_q == LAST) begin
        count_d = {W{1'b0}};
        state_d = ST_ACTIVE;
      end else begin
        count_d = count_q + W'(1'b1);
        case (state_q)
          ST_ACTIVE: if (count_d == B_FRONT) state_d = ST_AFTER_ACTIVE; else state_d = state_q;
          ST_FRONT:  if (count_d == B_SYNC)  state_d = ST_AFTER_FRONT;  else state_d = state_q;
          ST_SYNC:   if (count_d == B_BACK)  state_d = ST_BACK;         else state_d = state_q;
          ST_BACK:   state_d = ST_BACK;
          default:   state_d = ST_BACK;
        endcase
      end
    end else begin
      count_d = count_q;
      state_d = state_q;
    end
  end

  // Counter and region registers; reset parks on the last pixel of the axis.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= LAST;
      state_q <= ST_BACK;
    end else begin
      count_q <= count_d;
      state_q <= state_d;
    end
  end

  assign count_o   = count_q;
  assign state_d_o = state_d;

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: two axis FSMs plus registered
// sync, data-enable and line/frame start outputs aligned with the counters.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter logic        H_POL    = 1'b0,
  parameter logic        V_POL    = 1'b0,
  parameter int unsigned CH_W     = DEF_CH_W,
  parameter int unsigned CV_W     = DEF_CV_W
) (
  input  logic            clk_25,
  input  logic            rst_n,
  input  logic            pix_en,
  input  logic            resync,
  output logic            h_sync,
  output logic            v_sync,
  output logic            de,
  output logic            line_start,
  output logic            frame_start,
  output logic [CH_W-1:0] count_H,
  output logic [CV_W-1:0] count_V
);

  logic     h_wrap_s, v_wrap_s, v_adv_s;
  axis_st_t h_st_d_s, v_st_d_s;

  logic h_sync_q, h_sync_d;
  logic v_sync_q, v_sync_d;
  logic de_q, de_d;
  logic line_start_q, line_start_d;
  logic frame_start_q, frame_start_d;

  assign v_adv_s = pix_en & h_wrap_s;

  vga_axis_fsm #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .W(CH_W)
  ) u_h_axis (
    .clk_i    (clk_25),
    .rst_ni   (rst_n),
    .clear_i  (resync),
    .advance_i(pix_en),
    .wrap_o   (h_wrap_s),
    .count_o  (count_H),
    .state_d_o(h_st_d_s)
  );

  vga_axis_fsm #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .W(CV_W)
  ) u_v_axis (
    .clk_i    (clk_25),
    .rst_ni   (rst_n),
    .clear_i  (resync),
    .advance_i(v_adv_s),
    .wrap_o   (v_wrap_s),
    .count_o  (count_V),
    .state_d_o(v_st_d_s)
  );

  // Decode from next-state so registered levels line up with the new counts.
  always_comb begin
    h_sync_d      = sync_level(h_st_d_s, H_POL);
    v_sync_d      = sync_level(v_st_d_s, V_POL);
    de_d          = (h_st_d_s == ST_ACTIVE) & (v_st_d_s == ST_ACTIVE);
    line_start_d  = ~resync & h_wrap_s;
    frame_start_d = ~resync & h_wrap_s & v_wrap_s;
  end

  // Output registers.
  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      h_sync_q      <= ~H_POL;
      v_sync_q      <= ~V_POL;
      de_q          <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      h_sync_q      <= h_sync_d;
      v_sync_q      <= v_sync_d;
      de_q          <= de_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign h_sync      = h_sync_q;
  assign v_sync      = v_sync_q;
  assign de          = de_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: three geometries driven by shared random stimulus and
// compared against a raster model built from plain (h,v) arithmetic.
module tb_vga_timing_gen;

  localparam int NI = 3;
  localparam int HA [NI] = '{640, 10, 6};
  localparam int HF [NI] = '{16, 0, 1};
  localparam int HS [NI] = '{96, 3, 2};
  localparam int HB [NI] = '{48, 2, 1};
  localparam int VA [NI] = '{480, 6, 4};
  localparam int VF [NI] = '{10, 2, 1};
  localparam int VS [NI] = '{2, 0, 2};
  localparam int VB [NI] = '{33, 1, 2};
  localparam int HP [NI] = '{0, 1, 0};
  localparam int VP [NI] = '{0, 1, 1};

  typedef struct {
    int h; int v;
    bit de; bit hs; bit vs; bit ls; bit fs;
  } exp_t;

  logic clk_25 = 1'b0;
  logic rst_n  = 1'b1;
  logic pix_en = 1'b0;
  logic resync = 1'b0;

  always #20 clk_25 = ~clk_25;

  logic       hs0, vs0, de0, ls0, fs0;
  logic [9:0] ch0, cv0;
  logic       hs1, vs1, de1, ls1, fs1;
  logic [3:0] ch1, cv1;
  logic       hs2, vs2, de2, ls2, fs2;
  logic [3:0] ch2, cv2;

  vga_timing_gen u_dut0 (
    .clk_25(clk_25), .rst_n(rst_n), .pix_en(pix_en), .resync(resync),
    .h_sync(hs0), .v_sync(vs0), .de(de0), .line_start(ls0), .frame_start(fs0),
    .count_H(ch0), .count_V(cv0)
  );

  vga_timing_gen #(
    .H_ACTIVE(HA[1]), .H_FP(HF[1]), .H_SYNC(HS[1]), .H_BP(HB[1]),
    .V_ACTIVE(VA[1]), .V_FP(VF[1]), .V_SYNC(VS[1]), .V_BP(VB[1]),
    .H_POL(1'b1), .V_POL(1'b1), .CH_W(4), .CV_W(4)
  ) u_dut1 (
    .clk_25(clk_25), .rst_n(rst_n), .pix_en(pix_en), .resync(resync),
    .h_sync(hs1), .v_sync(vs1), .de(de1), .line_start(ls1), .frame_start(fs1),
    .count_H(ch1), .count_V(cv1)
  );

  vga_timing_gen #(
    .H_ACTIVE(HA[2]), .H_FP(HF[2]), .H_SYNC(HS[2]), .H_BP(HB[2]),
    .V_ACTIVE(VA[2]), .V_FP(VF[2]), .V_SYNC(VS[2]), .V_BP(VB[2]),
    .H_POL(1'b0), .V_POL(1'b1), .CH_W(4), .CV_W(4)
  ) u_dut2 (
    .clk_25(clk_25), .rst_n(rst_n), .pix_en(pix_en), .resync(resync),
    .h_sync(hs2), .v_sync(vs2), .de(de2), .line_start(ls2), .frame_start(fs2),
    .count_H(ch2), .count_V(cv2)
  );

  logic [31:0] got_h [NI];
  logic [31:0] got_v [NI];
  logic [4:0]  got_f [NI];

  assign got_h[0] = 32'(ch0);
  assign got_v[0] = 32'(cv0);
  assign got_f[0] = {de0, hs0, vs0, ls0, fs0};
  assign got_h[1] = 32'(ch1);
  assign got_v[1] = 32'(cv1);
  assign got_f[1] = {de1, hs1, vs1, ls1, fs1};
  assign got_h[2] = 32'(ch2);
  assign got_v[2] = 32'(cv2);
  assign got_f[2] = {de2, hs2, vs2, ls2, fs2};

  int   mh [NI];
  int   mv [NI];
  bit   mls [NI];
  bit   mfs [NI];
  exp_t sb_q [NI][$];

  int n_checks = 0;
  int n_errors = 0;

  function automatic exp_t expect_of(input int i);
    exp_t e;
    bit h_on, v_on;
    h_on = (mh[i] >= HA[i] + HF[i]) && (mh[i] < HA[i] + HF[i] + HS[i]);
    v_on = (mv[i] >= VA[i] + VF[i]) && (mv[i] < VA[i] + VF[i] + VS[i]);
    e.h  = mh[i];
    e.v  = mv[i];
    e.de = (mh[i] < HA[i]) && (mv[i] < VA[i]);
    e.hs = h_on ? (HP[i] != 0) : (HP[i] == 0);
    e.vs = v_on ? (VP[i] != 0) : (VP[i] == 0);
    e.ls = mls[i];
    e.fs = mfs[i];
    return e;
  endfunction

  task automatic model_step(input bit rst, input bit pe, input bit rs);
    for (int i = 0; i < NI; i++) begin
      int ht, vt;
      ht = HA[i] + HF[i] + HS[i] + HB[i];
      vt = VA[i] + VF[i] + VS[i] + VB[i];
      if (rst || rs) begin
        mh[i] = ht - 1; mv[i] = vt - 1; mls[i] = 1'b0; mfs[i] = 1'b0;
      end else if (pe) begin
        mh[i] = (mh[i] + 1) % ht;
        if (mh[i] == 0) mv[i] = (mv[i] + 1) % vt;
        mls[i] = (mh[i] == 0);
        mfs[i] = (mh[i] == 0) && (mv[i] == 0);
      end else begin
        mls[i] = 1'b0; mfs[i] = 1'b0;
      end
      sb_q[i].push_back(expect_of(i));
    end
  endtask

  task automatic chk(input int i, input string name, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_errors++;
      $display("FAIL inst%0d %s got %0d want %0d at t=%0t", i, name, got, want, $time);
    end
  endtask

  task automatic cycle(input bit pe, input bit rs);
    @(negedge clk_25);
    pix_en = pe;
    resync = rs;
    model_step(!rst_n, pe, rs);
  endtask

  task automatic async_reset();
    @(posedge clk_25);
    #5;
    pix_en = 1'b0;
    resync = 1'b0;
    model_step(1'b1, 1'b0, 1'b0);
    rst_n = 1'b0;
  endtask

  task automatic release_reset();
    @(negedge clk_25);
    rst_n  = 1'b1;
    pix_en = 1'b0;
    resync = 1'b0;
    model_step(1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: every clock edge, and the instant reset asserts, present an output to compare.
  always @(posedge clk_25 or negedge rst_n) begin : monitor
    exp_t e;
    #1;
    for (int i = 0; i < NI; i++) begin
      if (sb_q[i].size() > 0) begin
        e = sb_q[i].pop_front();
        chk(i, "count_H", int'(got_h[i]), e.h);
        chk(i, "count_V", int'(got_v[i]), e.v);
        chk(i, "de", int'(got_f[i][4]), int'(e.de));
        chk(i, "h_sync", int'(got_f[i][3]), int'(e.hs));
        chk(i, "v_sync", int'(got_f[i][2]), int'(e.vs));
        chk(i, "line_start", int'(got_f[i][1]), int'(e.ls));
        chk(i, "frame_start", int'(got_f[i][0]), int'(e.fs));
      end
    end
  end

  initial begin
    async_reset();
    repeat (5) cycle(1'b0, 1'b0);
    release_reset();
    cycle(1'b1, 1'b0);
    repeat (1500) cycle(1'b1, 1'b0);

    // Reset lands mid-frame on the default geometry at (700,1).
    async_reset();
    repeat (3) cycle(1'b0, 1'b0);
    release_reset();

    repeat (2000) begin
      cycle(1'b1, 1'b0);
      cycle(1'b0, 1'b0);
    end

    repeat (300) cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b1);
    cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);

    repeat (3000) cycle($urandom_range(3, 0) != 0, $urandom_range(199, 0) == 0);

    repeat (2) @(negedge clk_25);
    for (int i = 0; i < NI; i++) chk(i, "scoreboard_drained", sb_q[i].size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
